// File: rtl/mem_port_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types, funct3 encodings and access-size helper for
//                the dual-lane memory port sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

  // Sequencer state: PASS issues both lanes, REPLAY issues the buffered lane 2
  typedef enum logic [0:0] {
    ST_PASS   = 1'b0,
    ST_REPLAY = 1'b1
  } seq_state_t;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Bytes touched by an access; zero marks the reserved no-access encoding
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      2'b10:   size = 3'd4;
      default: size = 3'd0;
    endcase
    return size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_sequencer_overlap.sv
`default_nettype none
// ============================================================================
//  Module      : byte_overlap_detect
//  Description : Combinational check whether two byte ranges [addr, addr+size)
//                share any byte, with addresses wrapping modulo 2^ADDRESS_WIDTH.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_overlap_detect #(
  parameter int ADDRESS_WIDTH = 17
) (
  input  logic [ADDRESS_WIDTH-1:0] addr_a,
  input  logic [2:0]               size_a,
  input  logic [ADDRESS_WIDTH-1:0] addr_b,
  input  logic [2:0]               size_b,
  output logic                     overlap
);

  logic [ADDRESS_WIDTH-1:0] dist_ab;
  logic [ADDRESS_WIDTH-1:0] dist_ba;
  logic [ADDRESS_WIDTH-1:0] size_a_ext;
  logic [ADDRESS_WIDTH-1:0] size_b_ext;

  // Two ranges intersect exactly when the start of one lies inside the other;
  // the modular distances make the test correct across the address wrap.
  always_comb begin
    dist_ab    = addr_b - addr_a;
    dist_ba    = addr_a - addr_b;
    size_a_ext = {{(ADDRESS_WIDTH-3){1'b0}}, size_a};
    size_b_ext = {{(ADDRESS_WIDTH-3){1'b0}}, size_b};
    overlap    = (size_a != 3'd0) && (size_b != 3'd0) &&
                 ((dist_ab < size_a_ext) || (dist_ba < size_b_ext));
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_sequencer
//  Description : Maps two issue lanes onto a dual-port memory. Store/store and
//                overlapping store/load pairs are serialized: lane 1 goes first,
//                lane 2 is buffered and replayed one cycle later on port 2.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_sequencer #(
  parameter int XLEN          = 32,
  parameter int ADDRESS_WIDTH = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemWrite1,
  input  logic            MemWrite2,
  input  logic            MemRead1,
  input  logic            MemRead2,
  input  logic [XLEN-1:0] Addr1,
  input  logic [XLEN-1:0] Addr2,
  input  logic [XLEN-1:0] WData1,
  input  logic [XLEN-1:0] WData2,
  input  logic [2:0]      Funct3_1,
  input  logic [2:0]      Funct3_2,
  output logic            WE1,
  output logic            WE2,
  output logic [XLEN-1:0] A1,
  output logic [XLEN-1:0] A2,
  output logic [XLEN-1:0] WD1,
  output logic [XLEN-1:0] WD2,
  output logic [2:0]      AddressingControl1,
  output logic [2:0]      AddressingControl2,
  output logic            Stall,
  output logic [15:0]     HazardCount
);

  import mem_pkg::*;

  seq_state_t        state;
  logic              buf_we;
  logic [XLEN-1:0]   buf_addr;
  logic [XLEN-1:0]   buf_wdata;
  logic [2:0]        buf_funct3;
  logic [15:0]       hazard_cnt;

  logic [2:0]        size1;
  logic [2:0]        size2;
  logic              store1;
  logic              store2;
  logic              load2;
  logic              overlap;
  logic              hazard;

  // Per-lane access sizes; the reserved encoding neither writes nor conflicts
  always_comb begin
    size1  = access_size(Funct3_1);
    size2  = access_size(Funct3_2);
    store1 = MemWrite1 && (size1 != 3'd0);
    store2 = MemWrite2 && (size2 != 3'd0);
    load2  = MemRead2  && (size2 != 3'd0);
  end

  byte_overlap_detect #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_overlap (
    .addr_a  (Addr1[ADDRESS_WIDTH-1:0]),
    .size_a  (size1),
    .addr_b  (Addr2[ADDRESS_WIDTH-1:0]),
    .size_b  (size2),
    .overlap (overlap)
  );

  // Any double store serializes so lane 2 lands last; a younger load only
  // waits when it reads bytes the older store is writing. An older load with
  // a younger store never conflicts because the read sees pre-store data.
  always_comb begin
    hazard = (state == ST_PASS) &&
             ((store1 && store2) || (store1 && load2 && overlap));
  end

  // Port steering: lane fields in PASS, buffered lane 2 on port 2 in REPLAY.
  // Port 1 keeps lane-1 address/funct3 during REPLAY so its read stays valid.
  always_comb begin
    A1                 = Addr1;
    WD1                = WData1;
    AddressingControl1 = Funct3_1;
    A2                 = Addr2;
    WD2                = WData2;
    AddressingControl2 = Funct3_2;
    WE1                = 1'b0;
    WE2                = 1'b0;
    Stall              = 1'b0;
    if (state == ST_REPLAY) begin
      A2                 = buf_addr;
      WD2                = buf_wdata;
      AddressingControl2 = buf_funct3;
      WE2                = buf_we;
    end else begin
      WE1   = store1;
      WE2   = store2 && !store1;
      Stall = hazard;
    end
    if (rst) begin
      WE1   = 1'b0;
      WE2   = 1'b0;
      Stall = 1'b0;
    end
  end

  // Sequencer state, replay buffer and saturating hazard counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_PASS;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      buf_funct3 <= 3'b000;
      hazard_cnt <= 16'd0;
    end else begin
      case (state)
        ST_PASS: begin
          if (hazard) begin
            state      <= ST_REPLAY;
            buf_we     <= store2;
            buf_addr   <= Addr2;
            buf_wdata  <= WData2;
            buf_funct3 <= Funct3_2;
            if (hazard_cnt != 16'hFFFF) begin
              hazard_cnt <= hazard_cnt + 16'd1;
            end
          end
        end
        ST_REPLAY: begin
          state <= ST_PASS;
        end
        default: begin
          state <= ST_PASS;
        end
      endcase
    end
  end

  assign HazardCount = hazard_cnt;

  // MemRead1 only matters to the memory, which reads port 1 every cycle
  logic unused_read1;
  assign unused_read1 = MemRead1;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_sequencer
//  Description : Directed bench with a byte-addressed memory model and a
//                queue of expected per-cycle port values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_sequencer;

  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam logic [2:0] LB = 3'b000, LW = 3'b010;

  logic        clk = 1'b0;
  logic        rst;
  logic        mw1, mw2, mr1, mr2;
  logic [31:0] ad1, ad2, wd1, wd2;
  logic [2:0]  f1, f2;
  logic        WE1, WE2, Stall;
  logic [31:0] A1, A2, WD1, WD2;
  logic [2:0]  AC1, AC2;
  logic [15:0] HazardCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we1;
    logic        we2;
    logic        stall;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] wd2;
    logic [2:0]  ac2;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [0:131071];

  mem_port_sequencer #(.XLEN(32), .ADDRESS_WIDTH(17)) dut (
    .clk(clk), .rst(rst),
    .MemWrite1(mw1), .MemWrite2(mw2), .MemRead1(mr1), .MemRead2(mr2),
    .Addr1(ad1), .Addr2(ad2), .WData1(wd1), .WData2(wd2),
    .Funct3_1(f1), .Funct3_2(f2),
    .WE1(WE1), .WE2(WE2), .A1(A1), .A2(A2), .WD1(WD1), .WD2(WD2),
    .AddressingControl1(AC1), .AddressingControl2(AC2),
    .Stall(Stall), .HazardCount(HazardCount)
  );

  always #5 clk = ~clk;

  function automatic int bsize(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int idx(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) & 32'h1FFFF);
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {mem[idx(a, 3)], mem[idx(a, 2)], mem[idx(a, 1)], mem[idx(a, 0)]};
  endfunction

  // Memory model: applies whatever the sequencer writes, port 1 then port 2
  always @(posedge clk) begin
    if (WE1) for (int i = 0; i < bsize(AC1); i++) mem[idx(A1, i)] <= WD1[8*i +: 8];
    if (WE2) for (int i = 0; i < bsize(AC2); i++) mem[idx(A2, i)] <= WD2[8*i +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive lanes at negedge, queue expectations, compare mid-cycle
  task automatic step(input string tag, input logic r,
                      input logic m1, input logic r1, input logic [31:0] x1, input logic [31:0] d1, input logic [2:0] g1,
                      input logic m2, input logic r2, input logic [31:0] x2, input logic [31:0] d2, input logic [2:0] g2,
                      input logic e_we1, input logic e_we2, input logic e_st,
                      input logic [31:0] e_a1, input logic [31:0] e_a2, input logic [31:0] e_wd2, input logic [2:0] e_ac2);
    exp_t e, got;
    @(negedge clk);
    rst = r; mw1 = m1; mr1 = r1; ad1 = x1; wd1 = d1; f1 = g1;
    mw2 = m2; mr2 = r2; ad2 = x2; wd2 = d2; f2 = g2;
    e.we1 = e_we1; e.we2 = e_we2; e.stall = e_st;
    e.a1 = e_a1; e.a2 = e_a2; e.wd2 = e_wd2; e.ac2 = e_ac2;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    chk({tag, ".we1"},   32'(WE1),   32'(got.we1));
    chk({tag, ".we2"},   32'(WE2),   32'(got.we2));
    chk({tag, ".stall"}, 32'(Stall), 32'(got.stall));
    chk({tag, ".a1"},    A1,         got.a1);
    chk({tag, ".a2"},    A2,         got.a2);
    chk({tag, ".wd2"},   WD2,        got.wd2);
    chk({tag, ".ac2"},   32'(AC2),   32'(got.ac2));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 0, 0, 32'h0, 32'h0, SB, 0, 0, 32'h0, 32'h0, SB,
         0, 0, 0, 32'h0, 32'h0, 32'h0, SB);
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    rst = 1'b1; mw1 = 0; mw2 = 0; mr1 = 0; mr2 = 0;
    ad1 = 0; ad2 = 0; wd1 = 0; wd2 = 0; f1 = SB; f2 = SB;

    // Reset gates enables while data passes through
    step("rst0", 1, 1, 0, 32'h10, 32'h1, SW, 1, 0, 32'h14, 32'h2, SW, 0, 0, 0, 32'h10, 32'h14, 32'h2, SW);
    step("rst1", 1, 1, 0, 32'h10, 32'h1, SW, 1, 0, 32'h14, 32'h2, SW, 0, 0, 0, 32'h10, 32'h14, 32'h2, SW);
    chk("hc_reset", 32'(HazardCount), 32'd0);
    idle("idle0");

    // Same-address double store; lane 2 inputs scrambled during replay
    step("ss_p", 0, 1, 0, 32'h100, 32'h11223344, SW, 1, 0, 32'h100, 32'hAABBCCDD, SW,
         1, 0, 1, 32'h100, 32'h100, 32'hAABBCCDD, SW);
    step("ss_r", 0, 1, 0, 32'h100, 32'h11223344, SW, 0, 1, 32'h999, 32'hDEADBEEF, LB,
         0, 1, 0, 32'h100, 32'h100, 32'hAABBCCDD, SW);
    chk("hc_ss", 32'(HazardCount), 32'd1);
    idle("ss_i");
    chk("mem_ss", rd_word(32'h100), 32'hAABBCCDD);

    // Byte store into the top byte of a word that lane 2 loads
    step("bl_p", 0, 1, 0, 32'h203, 32'h7F, SB, 0, 1, 32'h200, 32'h0, LW,
         1, 0, 1, 32'h203, 32'h200, 32'h0, LW);
    step("bl_r", 0, 1, 0, 32'h203, 32'h7F, SB, 0, 1, 32'h200, 32'h0, LW,
         0, 0, 0, 32'h203, 32'h200, 32'h0, LW);
    chk("rd2_bl", rd_word(A2), 32'h7F000000);
    chk("hc_bl", 32'(HazardCount), 32'd2);

    // Halfword store next to a byte load: no overlap, single cycle
    step("nh_p", 0, 1, 0, 32'h300, 32'hBEEF, SH, 0, 1, 32'h302, 32'h0, LB,
         1, 0, 0, 32'h300, 32'h302, 32'h0, LB);
    idle("nh_i");
    chk("hc_nh", 32'(HazardCount), 32'd2);
    chk("mem_nh", rd_word(32'h300), 32'h0000BEEF);

    // Last byte of the halfword: overlaps
    step("ah_p", 0, 1, 0, 32'h300, 32'hBEEF, SH, 0, 1, 32'h301, 32'h0, LB,
         1, 0, 1, 32'h300, 32'h301, 32'h0, LB);
    step("ah_r", 0, 1, 0, 32'h300, 32'hBEEF, SH, 0, 1, 32'h301, 32'h0, LB,
         0, 0, 0, 32'h300, 32'h301, 32'h0, LB);
    chk("hc_ah", 32'(HazardCount), 32'd3);

    // Word store wrapping past the top of the address space
    step("wr_p", 0, 1, 0, 32'h1FFFE, 32'h55667788, SW, 0, 1, 32'h1, 32'h0, LB,
         1, 0, 1, 32'h1FFFE, 32'h1, 32'h0, LB);
    step("wr_r", 0, 1, 0, 32'h1FFFE, 32'h55667788, SW, 0, 1, 32'h1, 32'h0, LB,
         0, 0, 0, 32'h1FFFE, 32'h1, 32'h0, LB);
    chk("hc_wr", 32'(HazardCount), 32'd4);
    chk("mem_wr", rd_word(32'h0), 32'h00005566);
    step("nw_p", 0, 1, 0, 32'h1FFF8, 32'h0, SW, 0, 1, 32'h1, 32'h0, LB,
         1, 0, 0, 32'h1FFF8, 32'h1, 32'h0, LB);

    // Older load with younger store to the same word proceeds together
    step("ls_p", 0, 0, 1, 32'h100, 32'h0, LW, 1, 0, 32'h100, 32'h0BADF00D, SW,
         0, 1, 0, 32'h100, 32'h100, 32'h0BADF00D, SW);
    idle("ls_i");
    chk("mem_ls", rd_word(32'h100), 32'h0BADF00D);
    chk("hc_ls", 32'(HazardCount), 32'd4);

    // Reset during replay drops the buffered store
    step("rr_p", 0, 1, 0, 32'h400, 32'h01010101, SW, 1, 0, 32'h400, 32'h02020202, SW,
         1, 0, 1, 32'h400, 32'h400, 32'h02020202, SW);
    step("rr_r", 1, 1, 0, 32'h400, 32'h01010101, SW, 1, 0, 32'h400, 32'h02020202, SW,
         0, 0, 0, 32'h400, 32'h400, 32'h02020202, SW);
    idle("rr_i");
    chk("hc_rr", 32'(HazardCount), 32'd0);
    chk("mem_rr", rd_word(32'h400), 32'h01010101);

    // Saturation: preload near the top, then keep issuing double stores
    @(negedge clk);
    force dut.hazard_cnt = 16'hFFFD;
    #1;
    release dut.hazard_cnt;
    for (int k = 0; k < 4; k++) begin
      step("sat_p", 0, 1, 0, 32'h500, 32'h1, SW, 1, 0, 32'h504, 32'h2, SW,
           1, 0, 1, 32'h500, 32'h504, 32'h2, SW);
      step("sat_r", 0, 1, 0, 32'h500, 32'h1, SW, 1, 0, 32'h504, 32'h2, SW,
           0, 1, 0, 32'h500, 32'h504, 32'h2, SW);
      chk("hc_sat", 32'(HazardCount), (k == 0) ? 32'hFFFE : 32'hFFFF);
    end
    idle("end_i");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
